// File: rtl/ultrasonic_echo_emulator.sv
// Ultrasonic range-sensor responder: accepts a trigger pulse, waits out the
// acoustic burst, then returns an echo whose width encodes the target distance.
module ultrasonic_echo_emulator #(
  parameter int unsigned TRIG_MIN_CYC  = 1000,
  parameter int unsigned BURST_DLY_CYC = 20000,
  parameter int unsigned CYC_PER_CM    = 5800,
  parameter int unsigned MIN_CM        = 2,
  parameter int unsigned MAX_CM        = 400,
  parameter int unsigned TIMEOUT_CYC   = 3800000,
  parameter int unsigned HOLDOFF_CYC   = 6000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger,
  input  logic [8:0] distance_cm,
  input  logic       object_present,
  output logic       echo,
  output logic       busy,
  output logic       trig_err
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [31:0] echo_w, echo_w_nxt;
  logic        err_nxt;
  logic        sync1, trig_s, trig_d;
  logic        rise, fall;
  logic [31:0] dist_ext, w_calc;

  assign rise = trig_s & ~trig_d;
  assign fall = ~trig_s & trig_d;

  always_comb begin
    dist_ext = 32'(distance_cm);
    if (!object_present || dist_ext > MAX_CM)
      w_calc = TIMEOUT_CYC;
    else if (dist_ext < MIN_CM)
      w_calc = MIN_CM * CYC_PER_CM;
    else
      w_calc = dist_ext * CYC_PER_CM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      trig_s   <= 1'b0;
      trig_d   <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      echo_w   <= '0;
      echo     <= 1'b0;
      busy     <= 1'b0;
      trig_err <= 1'b0;
    end else begin
      sync1    <= trigger;
      trig_s   <= sync1;
      trig_d   <= trig_s;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      echo_w   <= echo_w_nxt;
      echo     <= (state_nxt == ECHO);
      busy     <= (state_nxt != IDLE);
      trig_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    echo_w_nxt = echo_w;
    err_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = TRIG_HI;
          cnt_nxt   = 32'd1;
        end
      end
      TRIG_HI: begin
        if (fall) begin
          cnt_nxt = '0;
          if (cnt >= TRIG_MIN_CYC) begin
            state_nxt  = BURST;
            echo_w_nxt = w_calc;
          end else begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end else if (trig_s && cnt < TRIG_MIN_CYC) begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      // Runs BURST_DLY_CYC+1 cycles so echo lands BURST_DLY_CYC+3 cycles
      // after the first clock that sampled the raw trigger low.
      BURST: begin
        if (cnt == BURST_DLY_CYC) begin
          state_nxt = ECHO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      ECHO: begin
        if (cnt == echo_w - 32'd1) begin
          state_nxt = HOLDOFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      HOLDOFF: begin
        if (cnt == HOLDOFF_CYC - 32'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Self-checking bench for ultrasonic_echo_emulator with shortened timing
// parameters and a distance-to-width reference model.
module tb_ultrasonic_echo_emulator;

  localparam int unsigned P_TRIG = 10;
  localparam int unsigned P_BURST = 40;
  localparam int unsigned P_CPC = 3;
  localparam int unsigned P_MIN = 2;
  localparam int unsigned P_MAX = 400;
  localparam int unsigned P_TO = 1500;
  localparam int unsigned P_HOLD = 100;
  // Edges counted after the first edge that samples the raw trigger low.
  localparam int unsigned LAT = P_BURST + 3;
  localparam int unsigned ERR_LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trigger;
  logic [8:0] distance_cm;
  logic       object_present;
  logic       echo, busy, trig_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned echo_rises = 0;
  int unsigned err_pulses = 0;
  logic        echo_last = 1'b0;

  ultrasonic_echo_emulator #(
    .TRIG_MIN_CYC (P_TRIG),
    .BURST_DLY_CYC(P_BURST),
    .CYC_PER_CM   (P_CPC),
    .MIN_CM       (P_MIN),
    .MAX_CM       (P_MAX),
    .TIMEOUT_CYC  (P_TO),
    .HOLDOFF_CYC  (P_HOLD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .trigger       (trigger),
    .distance_cm   (distance_cm),
    .object_present(object_present),
    .echo          (echo),
    .busy          (busy),
    .trig_err      (trig_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (echo && !echo_last) echo_rises <= echo_rises + 1;
    if (trig_err) err_pulses <= err_pulses + 1;
    echo_last <= echo;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: no target or out of range -> timeout; otherwise clamp the
  // distance up to the minimum and scale by the round-trip time per cm.
  function automatic int unsigned model_width(input int unsigned d, input bit obj);
    int unsigned eff;
    if (!obj || d > P_MAX) return P_TO;
    eff = (d < P_MIN) ? P_MIN : d;
    return eff * P_CPC;
  endfunction

  task automatic pulse(input int unsigned n);
    trigger = 1'b1;
    repeat (n) @(posedge clk);
    #1 trigger = 1'b0;
  endtask

  task automatic measure_lat(input string tag);
    int unsigned n = 0;
    @(posedge clk);
    do begin @(posedge clk); #1; n++; end while (!echo && n < LAT + 50);
    check({tag, " latency"}, n, LAT);
  endtask

  task automatic measure_width(input string tag, input int unsigned exp_w);
    int unsigned n = 0;
    do begin @(posedge clk); #1; n++; end while (echo && n < P_TO + 100);
    check({tag, " width"}, n, exp_w);
  endtask

  task automatic measure_hold(input string tag);
    int unsigned n = 0;
    do begin @(posedge clk); #1; n++; end while (busy && n < P_HOLD + 50);
    check({tag, " holdoff"}, n, P_HOLD);
  endtask

  task automatic transaction(input string tag, input int unsigned w, input int unsigned d, input bit obj);
    int unsigned rises0;
    distance_cm = 9'(d);
    object_present = obj;
    rises0 = echo_rises;
    pulse(w);
    measure_lat(tag);
    measure_width(tag, model_width(d, obj));
    measure_hold(tag);
    check({tag, " one echo"}, echo_rises - rises0, 1);
  endtask

  initial begin
    int unsigned rises0, errs0, n;
    rst_n = 1'b0;
    trigger = 1'b0;
    distance_cm = '0;
    object_present = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset echo", echo, 0);
    check("reset busy", busy, 0);
    check("reset trig_err", trig_err, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    transaction("basic d100", P_TRIG, 100, 1'b1);

    // Short trigger: rejected with a single error pulse, no echo.
    rises0 = echo_rises;
    errs0 = err_pulses;
    pulse(P_TRIG - 1);
    @(posedge clk);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!trig_err && n < 20);
    check("short err latency", n, ERR_LAT);
    @(posedge clk); #1;
    check("short err one cycle", trig_err, 0);
    check("short busy", busy, 0);
    repeat (LAT + 50) @(posedge clk);
    #1;
    check("short no echo", echo_rises - rises0, 0);
    check("short err count", err_pulses - errs0, 1);

    transaction("clamp d1", P_TRIG, 1, 1'b1);
    transaction("clamp d0", P_TRIG, 0, 1'b1);
    transaction("edge d2", P_TRIG, 2, 1'b1);
    transaction("edge d400", P_TRIG, 400, 1'b1);
    transaction("range d401", P_TRIG, 401, 1'b1);
    transaction("noobj d50", P_TRIG, 50, 1'b0);

    // Trigger and distance change during ECHO must not disturb the pulse.
    rises0 = echo_rises;
    errs0 = err_pulses;
    distance_cm = 9'd50;
    object_present = 1'b1;
    pulse(P_TRIG);
    measure_lat("retrig");
    fork
      measure_width("retrig", model_width(50, 1'b1));
      begin
        repeat (20) @(posedge clk);
        #1 distance_cm = 9'd10;
        pulse(P_TRIG);
      end
    join
    measure_hold("retrig");
    repeat (30) @(posedge clk);
    #1;
    check("retrig echo count", echo_rises - rises0, 1);
    check("retrig no err", err_pulses - errs0, 0);
    check("retrig idle", busy, 0);

    // Trigger held high across HOLDOFF into IDLE is ignored until it re-rises.
    rises0 = echo_rises;
    distance_cm = 9'd20;
    pulse(P_TRIG);
    measure_lat("held");
    measure_width("held", model_width(20, 1'b1));
    trigger = 1'b1;
    measure_hold("held");
    repeat (60) @(posedge clk);
    #1;
    check("held busy", busy, 0);
    check("held no response", echo_rises - rises0, 1);
    trigger = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    transaction("after held", P_TRIG, 30, 1'b1);

    // Reset halfway through ECHO drops echo and busy immediately.
    distance_cm = 9'd100;
    pulse(P_TRIG);
    measure_lat("reset mid");
    repeat (model_width(100, 1'b1) / 2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("reset mid echo", echo, 0);
    check("reset mid busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    transaction("after reset", P_TRIG, 77, 1'b1);

    for (int i = 0; i < 8; i++) begin
      int unsigned d, w;
      bit obj;
      d = $urandom_range(0, 511);
      obj = ($urandom_range(0, 3) != 0);
      w = P_TRIG + $urandom_range(0, 20);
      transaction($sformatf("rand%0d", i), w, d, obj);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
